fetch_pc_ctrl: RTL

- Fetch-stage PC generator for the dual-issue pipeline.
- Holds the fetch PC and issues paired or single fetch requests to the instruction memory port.
- Selects the next PC with this priority: CP0 flush redirect, pending branch target, sequential increment.
- Consumes to_be_flushed/new_pc from the exception unit, and owns delay-slot sequencing when a taken branch's delay slot has not yet been fetched.

---
 rtl/fetch_pc_ctrl.sv | 101 ++++++++++
 1 files changed

// File: rtl/fetch_pc_ctrl.sv
// Fetch-stage PC generator for the dual-issue pipeline.
// Produces paired or single fetch requests and picks the next PC from a
// CP0 redirect, a pending branch target, or the sequential increment.
// A taken branch whose delay slot is still unfetched passes through WAIT_DS.
// In that state the delay slot is fetched alone. The PC then jumps to the
// saved target.
module fetch_pc_ctrl #(
  parameter logic [31:0] RESET_PC   = 32'hbfc00000,
  parameter int          PAIR_BYTES = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        flush,
  input  logic [31:0] flush_pc,
  input  logic        br_e,
  input  logic [31:0] br_addr,
  input  logic        br_ds_fetched,
  input  logic        inst_addr_ok,
  output logic        inst_req,
  output logic [31:0] pc_o,
  output logic [1:0]  lane_mask,
  output logic        pc_adel,
  output logic        fsm_wait_ds
);

  localparam logic [31:0] PAIR_STEP = 32'(PAIR_BYTES);
  localparam logic [31:0] WORD_STEP = 32'd4;

  typedef enum logic [1:0] {NORMAL, WAIT_DS, BR_GO} state_t;

  state_t      state, state_n;
  logic [31:0] pc, pc_n;
  logic [31:0] tgt, tgt_n;
  logic        req_en;
  logic        pair;
  logic        fire;

  // Decode the outputs from the registers.
  // Only inst_req also looks at rst directly, so it drops as soon as reset asserts.
  always_comb begin
    pc_adel     = |pc[1:0];
    pair        = ~pc[2] & (state == NORMAL) & ~pc_adel;
    lane_mask   = pair ? 2'b11 : 2'b01;
    inst_req    = req_en & rst & ~pc_adel;
    pc_o        = pc;
    fsm_wait_ds = (state == WAIT_DS);
    fire        = inst_req & inst_addr_ok & ~stall;
  end

  // Next-state selection: redirect, then branch, then delay-slot sequencing,
  // then the sequential advance. The remaining cases hold.
  always_comb begin
    state_n = state;
    pc_n    = pc;
    tgt_n   = tgt;
    if (flush) begin
      pc_n    = flush_pc;
      state_n = NORMAL;
      tgt_n   = '0;
    end else if (~stall & br_e & (state == NORMAL)) begin
      if (br_ds_fetched) begin
        pc_n    = br_addr;
        state_n = NORMAL;
      end else begin
        // pc is left as it is, so the next fetch reissues it alone as the delay slot.
        tgt_n   = br_addr;
        state_n = WAIT_DS;
      end
    end else if (fire) begin
      unique case (state)
        WAIT_DS: begin
          pc_n    = tgt;
          state_n = BR_GO;
        end
        BR_GO: begin
          // The target went out as a single-lane fetch, so step by one word.
          pc_n    = pc + WORD_STEP;
          state_n = NORMAL;
        end
        default: pc_n = pc + (pair ? PAIR_STEP : WORD_STEP);
      endcase
    end
  end

  // State registers. After reset is released, requests begin on the first edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc     <= RESET_PC;
      state  <= NORMAL;
      tgt    <= '0;
      req_en <= 1'b0;
    end else begin
      pc     <= pc_n;
      state  <= state_n;
      tgt    <= tgt_n;
      req_en <= 1'b1;
    end
  end

endmodule
